// File: rtl/data_mem_arbiter.sv
// Two-requester arbiter for the shared data-memory / chip-select port.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-break; otherwise port 0 wins ties.
module data_mem_arbiter #(
  parameter int DW       = 32,
  parameter int AW       = 32,
  parameter int READ_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          rvalid0,
  output logic [DW-1:0] rdata0,
  output logic          stall0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata1,
  output logic          stall1,
  output logic          mem_we,
  output logic          mem_re,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif
  localparam logic [3:0] LAT_INIT = 4'(READ_LAT);

  typedef enum logic [1:0] {IDLE, BUSY, WAIT, RESP} state_t;

  state_t        state_reg;
  logic          last_grant_reg;
  logic          owner_reg;
  logic          cmd_we_reg;
  logic          pend0_reg;
  logic          pend1_reg;
  logic [3:0]    lat_cnt_reg;

  logic          win_valid;
  logic          win_sel;
  logic          win_we;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_wdata;

  always_comb begin
    win_valid = req0 | req1;
    win_sel   = 1'b0;
    if (req0 && req1) begin
      win_sel = RR_EN ? ~last_grant_reg : 1'b0;
    end else if (req1) begin
      win_sel = 1'b1;
    end
    win_we    = win_sel ? we1    : we0;
    win_addr  = win_sel ? addr1  : addr0;
    win_wdata = win_sel ? wdata1 : wdata0;
  end

  // A port with a read in flight stays stalled until its response pulse.
  assign stall0 = (req0 && !gnt0 && !pend0_reg) || (pend0_reg && !rvalid0);
  assign stall1 = (req1 && !gnt1 && !pend1_reg) || (pend1_reg && !rvalid1);
  assign busy   = (state_reg != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      owner_reg      <= 1'b0;
      cmd_we_reg     <= 1'b0;
      pend0_reg      <= 1'b0;
      pend1_reg      <= 1'b0;
      lat_cnt_reg    <= '0;
      gnt0           <= 1'b0;
      gnt1           <= 1'b0;
      rvalid0        <= 1'b0;
      rvalid1        <= 1'b0;
      rdata0         <= '0;
      rdata1         <= '0;
      mem_we         <= 1'b0;
      mem_re         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
    end else begin
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      mem_we  <= 1'b0;
      mem_re  <= 1'b0;
      if (rvalid0) pend0_reg <= 1'b0;
      if (rvalid1) pend1_reg <= 1'b0;

      case (state_reg)
        IDLE, RESP: begin
          if (win_valid) begin
            cmd_we_reg     <= win_we;
            mem_addr       <= win_addr;
            mem_wdata      <= win_wdata;
            last_grant_reg <= win_sel;
            owner_reg      <= win_sel;
            gnt0           <= ~win_sel;
            gnt1           <= win_sel;
            mem_we         <= win_we;
            mem_re         <= ~win_we;
            // Setting a new pending read overrides the clear from rvalid above.
            if (!win_we) begin
              if (win_sel) pend1_reg <= 1'b1;
              else         pend0_reg <= 1'b1;
            end
            state_reg <= BUSY;
          end else begin
            state_reg <= IDLE;
          end
        end
        BUSY: begin
          if (cmd_we_reg) begin
            state_reg <= IDLE;
          end else begin
            lat_cnt_reg <= LAT_INIT;
            state_reg   <= WAIT;
          end
        end
        WAIT: begin
          lat_cnt_reg <= lat_cnt_reg - 4'd1;
          if (lat_cnt_reg == 4'd1) begin
            if (owner_reg) begin
              rdata1  <= mem_rdata;
              rvalid1 <= 1'b1;
            end else begin
              rdata0  <= mem_rdata;
              rvalid0 <= 1'b1;
            end
            state_reg <= RESP;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench: instance 0 uses READ_LAT=1, instance 1 uses READ_LAT=3.
// Stimulus pushes expected strobe/response events; a negedge monitor pops and compares them.
module tb_data_mem_arbiter;

  localparam int DW = 32;
  localparam int AW = 32;

  typedef struct packed {
    logic [0:0]  inst;
    logic        rv;
    logic [1:0]  strb;
    logic [1:0]  who;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] cyc;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_checks;
  int   n_pass;
  ev_t  exp_q[$];

  logic          req0 [2];
  logic          we0 [2];
  logic [AW-1:0] addr0 [2];
  logic [DW-1:0] wdata0 [2];
  logic          gnt0 [2];
  logic          rvalid0 [2];
  logic [DW-1:0] rdata0 [2];
  logic          stall0 [2];
  logic          req1 [2];
  logic          we1 [2];
  logic [AW-1:0] addr1 [2];
  logic [DW-1:0] wdata1 [2];
  logic          gnt1 [2];
  logic          rvalid1 [2];
  logic [DW-1:0] rdata1 [2];
  logic          stall1 [2];
  logic          mem_we [2];
  logic          mem_re [2];
  logic [AW-1:0] mem_addr [2];
  logic [DW-1:0] mem_wdata [2];
  logic [DW-1:0] mem_rdata [2];
  logic          busy [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] base_rd(input logic [31:0] a);
    if (a[7:0] == 8'h20) return 32'h12345678;
    return 32'hA500_0000 | {8'h00, a[7:0], 8'h00, a[7:0]};
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_inst
      localparam int LAT = (gi == 0) ? 1 : 3;
      logic [31:0] wr_mem [logic [7:0]];
      logic [31:0] pipe [LAT];

      data_mem_arbiter #(.DW(DW), .AW(AW), .READ_LAT(LAT)) u_dut (
        .clk(clk), .rst(rst),
        .req0(req0[gi]), .we0(we0[gi]), .addr0(addr0[gi]), .wdata0(wdata0[gi]),
        .gnt0(gnt0[gi]), .rvalid0(rvalid0[gi]), .rdata0(rdata0[gi]), .stall0(stall0[gi]),
        .req1(req1[gi]), .we1(we1[gi]), .addr1(addr1[gi]), .wdata1(wdata1[gi]),
        .gnt1(gnt1[gi]), .rvalid1(rvalid1[gi]), .rdata1(rdata1[gi]), .stall1(stall1[gi]),
        .mem_we(mem_we[gi]), .mem_re(mem_re[gi]), .mem_addr(mem_addr[gi]),
        .mem_wdata(mem_wdata[gi]), .mem_rdata(mem_rdata[gi]), .busy(busy[gi])
      );

      // Read data is valid exactly LAT cycles after the mem_re cycle, zero otherwise.
      always @(posedge clk) begin
        if (mem_we[gi]) wr_mem[mem_addr[gi][7:0]] = mem_wdata[gi];
        for (int k = LAT - 1; k > 0; k--) pipe[k] <= pipe[k-1];
        if (mem_re[gi])
          pipe[0] <= wr_mem.exists(mem_addr[gi][7:0]) ? wr_mem[mem_addr[gi][7:0]] : base_rd(mem_addr[gi]);
        else
          pipe[0] <= '0;
      end
      assign mem_rdata[gi] = pipe[LAT-1];
    end
  endgenerate

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h (cyc=%0d)", name, act, exp, cyc);
  endtask

  task automatic push_ev(input int inst, input logic rv, input logic [1:0] strb, input int port,
                         input logic [31:0] addr, input logic [31:0] data, input int at);
    ev_t e;
    e.inst = 1'(inst);
    e.rv   = rv;
    e.strb = strb;
    e.who  = (port == 1) ? 2'b10 : 2'b01;
    e.addr = addr;
    e.data = data;
    e.cyc  = 32'(at);
    exp_q.push_back(e);
  endtask

  task automatic push_wr(input int inst, input int port, input logic [31:0] a, input logic [31:0] d, input int at);
    push_ev(inst, 1'b0, 2'b10, port, a, d, at);
  endtask
  task automatic push_rd(input int inst, input int port, input logic [31:0] a, input int at);
    push_ev(inst, 1'b0, 2'b01, port, a, 32'h0, at);
  endtask
  task automatic push_rv(input int inst, input int port, input logic [31:0] d, input int at);
    push_ev(inst, 1'b1, 2'b00, port, 32'h0, d, at);
  endtask

  task automatic score(input ev_t obs);
    ev_t e;
    $display("ev inst=%0d rv=%0d strb=%b who=%b addr=%h data=%h cyc=%0d",
             obs.inst, obs.rv, obs.strb, obs.who, obs.addr, obs.data, obs.cyc);
    n_checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL unexpected_event: got inst=%0d rv=%0d who=%b cyc=%0d, required no event",
               obs.inst, obs.rv, obs.who, obs.cyc);
      return;
    end
    e = exp_q.pop_front();
    if (obs === e) n_pass++;
    else $display("FAIL event: got inst=%0d rv=%0d strb=%b who=%b addr=%h data=%h cyc=%0d, required inst=%0d rv=%0d strb=%b who=%b addr=%h data=%h cyc=%0d",
                  obs.inst, obs.rv, obs.strb, obs.who, obs.addr, obs.data, obs.cyc,
                  e.inst, e.rv, e.strb, e.who, e.addr, e.data, e.cyc);
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      ev_t obs;
      if (gnt0[i] || gnt1[i] || mem_we[i] || mem_re[i]) begin
        obs.inst = 1'(i);
        obs.rv   = 1'b0;
        obs.strb = {mem_we[i], mem_re[i]};
        obs.who  = {gnt1[i], gnt0[i]};
        obs.addr = mem_addr[i];
        obs.data = mem_we[i] ? mem_wdata[i] : 32'h0;
        obs.cyc  = 32'(cyc);
        score(obs);
      end
      if (rvalid0[i] || rvalid1[i]) begin
        obs.inst = 1'(i);
        obs.rv   = 1'b1;
        obs.strb = 2'b00;
        obs.who  = {rvalid1[i], rvalid0[i]};
        obs.addr = 32'h0;
        obs.data = rvalid1[i] ? rdata1[i] : rdata0[i];
        obs.cyc  = 32'(cyc);
        score(obs);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  initial begin
    int t;
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req0[i] = 1'b0; we0[i] = 1'b0; addr0[i] = '0; wdata0[i] = '0;
      req1[i] = 1'b0; we1[i] = 1'b0; addr1[i] = '0; wdata1[i] = '0;
    end
    repeat (3) step();
    for (int i = 0; i < 2; i++) begin
      chk("reset_busy", 64'(busy[i]), 64'd0);
      chk("reset_ctrl", 64'({gnt0[i], gnt1[i], rvalid0[i], rvalid1[i], mem_we[i], mem_re[i], stall0[i], stall1[i]}), 64'd0);
      chk("reset_data", 64'(mem_addr[i] | mem_wdata[i] | rdata0[i] | rdata1[i]), 64'd0);
    end
    rst = 1'b1;
    step();

    // Port 0 write, READ_LAT=1 instance
    t = cyc;
    req0[0] = 1'b1; we0[0] = 1'b1; addr0[0] = 32'h10; wdata0[0] = 32'hDEADBEEF;
    push_wr(0, 0, 32'h10, 32'hDEADBEEF, t + 1);
    step();
    chk("wr_busy_c1", 64'(busy[0]), 64'd1);
    chk("wr_stall0_c1", 64'(stall0[0]), 64'd0);
    req0[0] = 1'b0; we0[0] = 1'b0;
    step();
    chk("wr_busy_c2", 64'(busy[0]), 64'd0);
    step();

    // Port 1 read, READ_LAT=1
    t = cyc;
    req1[0] = 1'b1; we1[0] = 1'b0; addr1[0] = 32'h20;
    push_rd(0, 1, 32'h20, t + 1);
    push_rv(0, 1, 32'h12345678, t + 3);
    step();
    chk("rd1_stall_c1", 64'(stall1[0]), 64'd1);
    req1[0] = 1'b0;
    step();
    chk("rd1_stall_c2", 64'(stall1[0]), 64'd1);
    step();
    chk("rd1_stall_c3", 64'(stall1[0]), 64'd0);
    step();
    chk("rd1_rdata_hold", 64'(rdata1[0]), 64'h12345678);

    // Both ports hold read requests: four back-to-back grants
    t = cyc;
    req0[0] = 1'b1; we0[0] = 1'b0; addr0[0] = 32'h30;
    req1[0] = 1'b1; we1[0] = 1'b0; addr1[0] = 32'h34;
    for (int k = 0; k < 4; k++) begin
      int p;
`ifdef ARB_ROUND_ROBIN_EN
      p = k % 2;
`else
      p = 0;
`endif
      push_rd(0, p, (p == 1) ? 32'h34 : 32'h30, t + 1 + 3 * k);
      push_rv(0, p, (p == 1) ? 32'hA5340034 : 32'hA5300030, t + 3 + 3 * k);
    end
    for (int k = 1; k <= 10; k++) begin
      step();
`ifndef ARB_ROUND_ROBIN_EN
      chk("fixed_stall1_high", 64'(stall1[0]), 64'd1);
`endif
    end
    req0[0] = 1'b0; req1[0] = 1'b0;
    repeat (4) step();
    chk("tie_idle", 64'(busy[0]), 64'd0);

    // READ_LAT=3: port 0 write then read of the same address
    t = cyc;
    req0[1] = 1'b1; we0[1] = 1'b1; addr0[1] = 32'h40; wdata0[1] = 32'hCAFEF00D;
    push_wr(1, 0, 32'h40, 32'hCAFEF00D, t + 1);
    push_rd(1, 0, 32'h40, t + 3);
    push_rv(1, 0, 32'hCAFEF00D, t + 7);
    step();
    we0[1] = 1'b0;
    step();
    step();
    req0[1] = 1'b0;
    step();
    chk("lat3_wait_busy", 64'(busy[1]), 64'd1);
    chk("lat3_wait_stall0", 64'(stall0[1]), 64'd1);
    repeat (3) step();
    chk("lat3_rdata", 64'(rdata0[1]), 64'hCAFEF00D);
    step();

    // Reset in the middle of a port-1 read wait
    t = cyc;
    req1[1] = 1'b1; we1[1] = 1'b0; addr1[1] = 32'h20;
    push_rd(1, 1, 32'h20, t + 1);
    step();
    req1[1] = 1'b0;
    step();
    step();
    chk("midwait_busy", 64'(busy[1]), 64'd1);
    rst = 1'b0;
    #1;
    chk("async_rst_busy", 64'(busy[1]), 64'd0);
    chk("async_rst_ctrl", 64'({gnt0[1], gnt1[1], rvalid0[1], rvalid1[1], mem_we[1], mem_re[1], stall1[1]}), 64'd0);
    chk("async_rst_data", 64'(mem_addr[1] | mem_wdata[1] | rdata0[1] | rdata1[1]), 64'd0);
    step();
    step();
    rst = 1'b1;
    repeat (8) step();

    // First tie after reset goes to port 0, then port 1
    t = cyc;
    req0[1] = 1'b1; we0[1] = 1'b1; addr0[1] = 32'h50; wdata0[1] = 32'h11111111;
    req1[1] = 1'b1; we1[1] = 1'b1; addr1[1] = 32'h54; wdata1[1] = 32'h22222222;
    push_wr(1, 0, 32'h50, 32'h11111111, t + 1);
    push_wr(1, 1, 32'h54, 32'h22222222, t + 3);
    step();
    req0[1] = 1'b0; we0[1] = 1'b0;
    step();
    step();
    req1[1] = 1'b0; we1[1] = 1'b0;
    repeat (3) step();
    chk("final_idle", 64'(busy[1]), 64'd0);

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Shares the single data-memory / chip-select port (RAM plus GPIO mapping) between two requesters.
  - Port 0: CPU pipeline memory stage.
  - Port 1: auxiliary master (program/data loader, debug).
- Sequences each access as a grant, a memory strobe, an optional read-latency wait and a response.
- Produces a per-port stall so the pipeline freezes its EX/MEM register while waiting.
- Sits between the EX/MEM pipeline register and the memory controller.

Parameters:
- DW, 32, data width.
- AW, 32, address width.
- READ_LAT, 1, cycles from the mem_re cycle to mem_rdata valid. Legal range is 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req0  in  1  port 0 access request.
- we0  in  1  port 0 write (1) / read (0).
- addr0  in  AW  port 0 address.
- wdata0  in  DW  port 0 write data.
- gnt0  out  1  port 0 request accepted, 1-cycle pulse.
- rvalid0  out  1  port 0 read data valid, 1-cycle pulse.
- rdata0  out  DW  port 0 read data.
- stall0  out  1  port 0 must hold (combinational).
- req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1, stall1: same as port 0, for port 1.
- mem_we  out  1  memory write strobe.
- mem_re  out  1  memory read strobe.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data.
- busy  out  1  arbiter not in IDLE.

Behaviour:
- Reset (rst=0, async) puts the arbiter in this state:
  - state=IDLE.
  - All outputs 0: gnt*, rvalid*, rdata*, mem_*, busy.
  - Latched command cleared.
  - last_grant=1, so port 0 wins first.
  - Latency counter=0.
  - Any outstanding read is dropped with no rvalid.
- FSM states: IDLE, BUSY, WAIT, RESP.
- Arbitration happens only at the clock edge ending IDLE or RESP.
  - If any req is high, latch the winner's we/addr/wdata, set last_grant to the winner, go to BUSY.
  - Otherwise go to IDLE.
- Winner selection:
  - Only one req high: that port wins.
  - Both high: the port that is not last_grant wins (round-robin).
- BUSY, exactly 1 cycle:
  - gnt of the winner = 1. Registered, so it is high only during this cycle.
  - mem_addr / mem_wdata come from the latched command.
  - Write: mem_we=1, next state is IDLE. No rvalid for writes.
  - Read: mem_re=1, counter loaded with READ_LAT, next state is WAIT.
- WAIT:
  - mem_addr is held; mem_re=0.
  - Counter decrements each cycle.
  - In the cycle where counter==1, mem_rdata is captured at the edge and the next state is RESP.
- RESP, 1 cycle:
  - rvalid of the owner = 1; rdata of the owner = captured data.
  - Arbitration is evaluated here, so back-to-back reads are possible.
- rdataX holds its last captured value until the next capture or reset.
- Requester rules:
  - req/we/addr/wdata stay stable until gnt is seen.
  - req may drop or re-assert on the cycle after gnt.
  - A request dropped before gnt is a protocol violation; the arbiter still completes the latched command.
- stallX = (reqX && !gntX && !pending_read_X) || (pending_read_X && !rvalidX).
  - pending_read_X is set at the BUSY edge of a read owned by X.
  - It clears when rvalidX is high.
- Timing, port 0 read with READ_LAT=1 and req0 first sampled at edge 0:
  - Cycle 1: gnt0, mem_re.
  - Cycle 2: WAIT, data sampled.
  - Cycle 3: rvalid0.
- Timing, write: gnt0 and mem_we in cycle 1; IDLE in cycle 2.
- busy = (state != IDLE).

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: round-robin tie-break as described above.
- Undefined: fixed priority, port 0 always wins ties. last_grant is still maintained but unused.

Test Plan:
- Reset check: assert rst=0 mid-WAIT of a port-1 read.
  - All outputs go to 0 immediately, asynchronously.
  - After release, no rvalid1 appears.
  - First tie goes to port 0.
- Port 0 write: req0=1, we0=1, addr0=0x10, wdata0=0xDEADBEEF.
  - gnt0 and mem_we=1 with mem_addr=0x10, mem_wdata=0xDEADBEEF in cycle 1.
  - busy=0 in cycle 2.
- Port 1 read, READ_LAT=1: memory model returns 0x12345678 for addr 0x20.
  - rvalid1=1 and rdata1=0x12345678 exactly 3 cycles after the request edge.
  - stall1 is high through cycle 2.
- Simultaneous reads, req0=req1=1 held (macro defined).
  - Grants alternate 0, 1, 0, 1.
  - A new gnt occurs in every RESP cycle.
- Same stimulus, macro undefined:
  - gnt0 every time, gnt1 never.
  - stall1 stays high.
- READ_LAT=3:
  - mem_re is high for 1 cycle.
  - Data is sampled 3 cycles later.
  - rvalid arrives 5 cycles after the request edge.
  - Interleaved write then read on port 0 completes with the correct ordering.
